// File: rtl/ultrasonic_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_pkg
//   Shared definitions for the ultrasonic ranging blocks: the echo_meter FSM
//   state type, the default timing constants for a 25 MHz clock, and the
//   9-bit distance type that the display logic also consumes.
//
//   No ports (package).
// ---------------------------------------------------------------------------
package ultrasonic_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } meter_state_t;

    // 58 us of round-trip echo per centimetre at 25 MHz.
    localparam int DEF_TICKS_PER_CM = 1450;
    // 20 ms allowed between arming and the echo rising.
    localparam int DEF_WAIT_LIMIT   = 500000;
    // Largest distance the sensor is trusted to report.
    localparam int DEF_MAX_CM       = 400;

    localparam int DISTANCE_W = 9;
    typedef logic [DISTANCE_W-1:0] distance_t;

    // Bits needed for a counter that runs 0..limit-1, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// ---------------------------------------------------------------------------
// echo_sync
//   Brings the raw asynchronous echo line into the clk_in domain through a
//   two-flop synchronizer and produces single-cycle rise/fall pulses from the
//   synchronized level. Edges appear two cycles after the pin changes.
//
//   Optional feature, macro ECHO_GLITCH_FILTER_EN: the synchronized level is
//   only accepted once it has held the same value for four consecutive
//   samples. This delays both edges by four more cycles and swallows any
//   pulse shorter than that.
//
//   Ports:
//     clk_in     in   clock, all flops on the rising edge
//     rst_n      in   asynchronous active-low reset
//     echo       in   raw sensor echo line (asynchronous)
//     echo_rise  out  one-cycle pulse on a rising edge of the accepted level
//     echo_fall  out  one-cycle pulse on a falling edge of the accepted level
// ---------------------------------------------------------------------------
module echo_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic echo,
    output logic echo_rise,
    output logic echo_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

    // Synchronizer chain: pure shift, no logic between the two flops.
    always_comb begin
        sync1_d = echo;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef ECHO_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] run_q, run_d;

    // run counts how many samples in a row have disagreed with the accepted
    // level; the fourth disagreeing sample flips the accepted level. Any
    // agreeing sample restarts the count, so short spikes never get through.
    always_comb begin
        filt_d = filt_q;
        run_d  = 2'd0;
        if (sync2_q != filt_q) begin
            if (run_q == 2'd3) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            run_q  <= 2'd0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Edge detector: remember the previous accepted level.
    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // A line that is already high produces no rise here; it has to go low
    // and come back before another rise pulse appears.
    assign echo_rise = level & ~prev_q;
    assign echo_fall = ~level & prev_q;

endmodule

// File: rtl/echo_meter.sv
// ---------------------------------------------------------------------------
// echo_meter
//   Times the echo pulse of an ultrasonic range sensor and reports the
//   distance in whole centimetres. After the trigger pulse the controller
//   strobes start; the block then waits for the echo to rise, measures how
//   long it stays high in units of TICKS_PER_CM clock cycles, and publishes
//   the completed centimetre count with a one-cycle valid strobe. A missing
//   echo (no rise within WAIT_LIMIT cycles) or an echo longer than MAX_CM
//   centimetres ends the measurement with the sticky timeout flag instead.
//
//   Parameters:
//     TICKS_PER_CM  clk_in cycles per centimetre of distance
//     WAIT_LIMIT    cycles allowed from arming to echo rise
//     MAX_CM        distance at which a still-high echo is abandoned
//
//   Ports:
//     clk_in       in   25 MHz clock, all logic on its rising edge
//     rst_n        in   asynchronous active-low reset
//     start        in   one-cycle arm strobe at the end of the trigger pulse
//     echo         in   raw asynchronous sensor echo line
//     distance_cm  out  last successfully measured distance
//     valid        out  one-cycle strobe when distance_cm updates
//     timeout      out  sticky, set when the last measurement failed
//     busy         out  high while waiting for or measuring an echo
//
//   Optional feature, macro ECHO_GLITCH_FILTER_EN: enables the echo glitch
//   filter inside echo_sync (four extra cycles of latency on both edges).
// ---------------------------------------------------------------------------
module echo_meter
    import ultrasonic_pkg::*;
#(
    parameter int TICKS_PER_CM = DEF_TICKS_PER_CM,
    parameter int WAIT_LIMIT   = DEF_WAIT_LIMIT,
    parameter int MAX_CM       = DEF_MAX_CM
) (
    input  logic      clk_in,
    input  logic      rst_n,
    input  logic      start,
    input  logic      echo,
    output distance_t distance_cm,
    output logic      valid,
    output logic      timeout,
    output logic      busy
);

    localparam int WAIT_W  = cnt_width(WAIT_LIMIT);
    localparam int PRESC_W = cnt_width(TICKS_PER_CM);
    localparam int CM_W    = cnt_width(MAX_CM);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CM - 1);
    localparam logic [CM_W-1:0]    CM_LAST    = CM_W'(MAX_CM - 1);

    meter_state_t        state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [CM_W-1:0]     cm_q, cm_d;
    distance_t           dist_q, dist_d;
    logic                timeout_q, timeout_d;

    logic echo_rise;
    logic echo_fall;
    logic presc_wrap;

    echo_sync u_echo_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .echo      (echo),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    assign presc_wrap = (presc_q == PRESC_LAST);

    // Next-state and counter logic. Counters hold their value by default and
    // only move in the state that owns them. The wait counter covers
    // 0..WAIT_LIMIT-1 and the cm counter 0..MAX_CM-1; the step that would
    // take either one to its limit is the timeout, so neither can wrap.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        presc_d    = presc_q;
        cm_d       = cm_q;
        dist_d     = dist_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_RISE;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end

            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    presc_d = '0;
                    cm_d    = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            MEASURE: begin
                if (echo_fall) begin
                    // The fall cycle is still echo-high time, so a wrap
                    // landing on it completes one more centimetre.
                    state_d = DONE;
                    if (presc_wrap) begin
                        dist_d = distance_t'(cm_q) + 1'b1;
                    end else begin
                        dist_d = distance_t'(cm_q);
                    end
                end else if (presc_wrap) begin
                    if (cm_q == CM_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        presc_d = '0;
                        cm_d    = cm_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            DONE: begin
                if (start) begin
                    state_d    = WAIT_RISE;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            presc_q    <= '0;
            cm_q       <= '0;
            dist_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            presc_q    <= presc_d;
            cm_q       <= cm_d;
            dist_q     <= dist_d;
            timeout_q  <= timeout_d;
        end
    end

    // DONE lasts exactly one cycle, so valid is simply the state decode.
    assign valid       = (state_q == DONE);
    assign busy        = (state_q == WAIT_RISE) || (state_q == MEASURE);
    assign timeout     = timeout_q;
    assign distance_cm = dist_q;

endmodule

// File: tb/tb_echo_meter.sv
// ---------------------------------------------------------------------------
// tb_echo_meter
//   Self-checking bench for echo_meter. The expected outputs come from a
//   timeline model: each measurement is described by when start is sampled,
//   when the echo pin rises and how long it stays high, and the model turns
//   that into the cycles at which busy, valid, timeout and distance_cm must
//   change (edges seen 2 cycles late, plus 4 with ECHO_GLITCH_FILTER_EN;
//   distance = high cycles / TICKS_PER_CM). A compare loop checks every
//   cycle out of reset, and literal checks pin the key results.
//   Small WAIT_LIMIT and MAX_CM keep the run short; TICKS_PER_CM stays at
//   its real value so the centimetre arithmetic is exercised as built.
// ---------------------------------------------------------------------------
module tb_echo_meter;

    localparam int T  = 1450;
    localparam int WL = 2000;
    localparam int MC = 11;
`ifdef ECHO_GLITCH_FILTER_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       echo   = 1'b0;
    logic [8:0] distance_cm;
    logic       valid;
    logic       timeout;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int valid_seen = 0;
    int cyc        = 0;

    // Timeline model state.
    int         sch_start   = -1;
    int         sch_end     = -1;
    bit         sch_timeout = 1'b0;
    int         sch_dist    = 0;
    logic       exp_busy    = 1'b0;
    logic       exp_valid   = 1'b0;
    logic       exp_timeout = 1'b0;
    logic [8:0] exp_dist    = 9'd0;

    echo_meter #(
        .TICKS_PER_CM (T),
        .WAIT_LIMIT   (WL),
        .MAX_CM       (MC)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .echo        (echo),
        .distance_cm (distance_cm),
        .valid       (valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    // 25 MHz clock.
    always #20 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_in);
        #1;
    endtask

    // Model: advances the cycle count and applies the scheduled changes.
    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                exp_busy    = 1'b0;
                exp_valid   = 1'b0;
                exp_timeout = 1'b0;
                exp_dist    = 9'd0;
                sch_start   = -1;
                sch_end     = -1;
            end else begin
                cyc++;
                exp_valid = 1'b0;
                if (cyc == sch_start) begin
                    exp_busy    = 1'b1;
                    exp_timeout = 1'b0;
                end
                if (cyc == sch_end) begin
                    exp_busy = 1'b0;
                    if (sch_timeout) begin
                        exp_timeout = 1'b1;
                    end else begin
                        exp_valid = 1'b1;
                        exp_dist  = 9'(sch_dist);
                    end
                end
            end
        end
    end

    // Compare every cycle out of reset, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (valid === 1'b1) valid_seen++;
            if (rst_n) begin
                checkOutput("valid",       int'(valid),       int'(exp_valid));
                checkOutput("busy",        int'(busy),        int'(exp_busy));
                checkOutput("timeout",     int'(timeout),     int'(exp_timeout));
                checkOutput("distance_cm", int'(distance_cm), int'(exp_dist));
            end
        end
    end

    // One measurement. high == 0 means the echo never rises.
    task automatic applyStimulus(input int delay, input int high, input bit pre_high,
                                 input bit poke, input bit spike);
        int s;
        int r;
        if (pre_high) begin
            echo = 1'b1;
            tick(10);
        end
        s           = cyc + 1;
        sch_timeout = 1'b0;
        sch_end     = -1;
        sch_start   = s;
        if (high == 0) begin
            sch_end     = s + WL;
            sch_timeout = 1'b1;
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (pre_high) begin
            tick(20);
            echo = 1'b0;
            tick(20);
        end else begin
            tick(delay);
        end
        if (spike) begin
            echo = 1'b1;
            tick(2);
            echo = 1'b0;
            tick(30);
            checkOutput("spike_busy", int'(busy), 1);
        end
        if (high > 0) begin
            r = cyc + 1;
            if (high > MC * T) begin
                sch_end     = r + 2 + EXTRA + MC * T;
                sch_timeout = 1'b1;
            end else begin
                sch_end  = r + high + 2 + EXTRA;
                sch_dist = high / T;
            end
            echo = 1'b1;
            if (poke) begin
                tick(high / 2);
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(high - high / 2 - 1);
            end else begin
                tick(high);
            end
            echo = 1'b0;
        end
        if (sch_end + 3 > cyc) tick(sch_end + 3 - cyc);
        tick(5);
    endtask

    // Watchdog: the run is a fixed sequence of bounded waits.
    initial begin
        #(150000 * 40);
        $display("[TB] FAIL watchdog: actual cycle %0d, required finish before 150000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0;
        #5;
        checkOutput("reset_distance", int'(distance_cm), 0);
        checkOutput("reset_valid",    int'(valid),       0);
        checkOutput("reset_timeout",  int'(timeout),     0);
        checkOutput("reset_busy",     int'(busy),        0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] 14500-cycle echo");
        v0 = valid_seen;
        applyStimulus(100, 14500, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_distance", int'(distance_cm), 10);
        checkOutput("t1_timeout",  int'(timeout),     0);
        checkOutput("t1_valids",   valid_seen - v0,   1);
        checkOutput("t1_busy",     int'(busy),        0);

        $display("[TB] 14499-cycle echo");
        v0 = valid_seen;
        applyStimulus(100, 14499, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_distance", int'(distance_cm), 9);
        checkOutput("t2_valids",   valid_seen - v0,   1);

        $display("[TB] echo held past MAX_CM");
        v0 = valid_seen;
        applyStimulus(100, MC * T + 600, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_timeout",  int'(timeout),     1);
        checkOutput("t3_distance", int'(distance_cm), 9);
        checkOutput("t3_valids",   valid_seen - v0,   0);
        checkOutput("t3_busy",     int'(busy),        0);

        $display("[TB] no echo");
        v0 = valid_seen;
        applyStimulus(100, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_timeout",  int'(timeout),     1);
        checkOutput("t4_busy",     int'(busy),        0);
        checkOutput("t4_valids",   valid_seen - v0,   0);
        checkOutput("t4_distance", int'(distance_cm), 9);

        $display("[TB] echo already high when armed");
        v0 = valid_seen;
        applyStimulus(0, 2900, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_distance", int'(distance_cm), 2);
        checkOutput("t5_timeout",  int'(timeout),     0);
        checkOutput("t5_valids",   valid_seen - v0,   1);

        $display("[TB] start pulsed while measuring");
        v0 = valid_seen;
        applyStimulus(60, 4400, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_distance", int'(distance_cm), 3);
        checkOutput("t6_valids",   valid_seen - v0,   1);

`ifdef ECHO_GLITCH_FILTER_EN
        $display("[TB] 2-cycle spike before the real echo");
        v0 = valid_seen;
        applyStimulus(50, 1450, 1'b0, 1'b0, 1'b1);
        checkOutput("t7_distance", int'(distance_cm), 1);
        checkOutput("t7_valids",   valid_seen - v0,   1);
`endif

        $display("[TB] reset during MEASURE");
        v0          = valid_seen;
        sch_timeout = 1'b0;
        sch_end     = -1;
        sch_start   = cyc + 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(50);
        echo = 1'b1;
        tick(3000);
        checkOutput("t8_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t8_distance", int'(distance_cm), 0);
        checkOutput("t8_valid",    int'(valid),       0);
        checkOutput("t8_timeout",  int'(timeout),     0);
        checkOutput("t8_busy",     int'(busy),        0);
        tick(5);
        rst_n = 1'b1;
        tick(100);
        echo = 1'b0;
        tick(50);
        checkOutput("t8_valids_after", valid_seen - v0,   0);
        checkOutput("t8_distance_after", int'(distance_cm), 0);
        checkOutput("t8_busy_after",   int'(busy),        0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/echo_meter.md
ECHO_METER -- requirements
Module: echo_meter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_CM, default 1450, giving clk_in cycles per centimetre (58 us at 25 MHz).
REQ-002 The block SHALL have parameter WAIT_LIMIT, default 500000, giving the maximum cycles from arm to echo rise (20 ms).
REQ-003 The block SHALL have parameter MAX_CM, default 400, giving the maximum reportable distance in cm.
REQ-004 The block SHALL have port clk_in, input, 1 bit: single 25 MHz clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle arm strobe, issued when the trigger pulse ends.
REQ-007 The block SHALL have port echo, input, 1 bit: raw asynchronous sensor echo line.
REQ-008 The block SHALL have port distance_cm, output, 9 bits: last measured distance.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle strobe, high when distance_cm updates.
REQ-010 The block SHALL have port timeout, output, 1 bit: sticky flag, set when the last measurement failed.
REQ-011 The block SHALL have port busy, output, 1 bit: high in WAIT_RISE and MEASURE.

Function
REQ-012 echo SHALL pass through a 2-flop synchronizer; rise and fall SHALL be detected on the synchronized signal, giving 2 cycles of added latency.
REQ-013 The FSM SHALL have states IDLE, WAIT_RISE, MEASURE and DONE.
REQ-014 IDLE/DONE + start -> WAIT_RISE: cycle counter cleared, timeout cleared.
REQ-015 start in WAIT_RISE or MEASURE SHALL be ignored.
REQ-016 WAIT_RISE + synchronized rise -> MEASURE: prescaler and cm counter cleared.
REQ-017 WAIT_RISE: wait counter reaching WAIT_LIMIT without a rise -> IDLE, timeout set, no valid.
REQ-018 An echo line already high on entry to WAIT_RISE SHALL NOT count as a rise; a fall then a rise is required.
REQ-019 MEASURE: prescaler counts 0..TICKS_PER_CM-1 and wraps; on each wrap the cm counter increments by 1.
REQ-020 MEASURE + synchronized fall -> DONE: distance_cm loaded with the cm counter (completed cm only, remainder truncated).
REQ-021 MEASURE: cm counter reaching MAX_CM before the fall -> IDLE, timeout set, distance_cm unchanged, no valid.
REQ-022 DONE SHALL last exactly one cycle with valid=1, then go to IDLE unless start is asserted in that cycle (then WAIT_RISE).
REQ-023 valid SHALL assert on the cycle after the synchronized fall is detected.
REQ-024 Counter widths SHALL be ceil(log2) of their limits; no counter SHALL wrap past its limit.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE; distance_cm=0; valid=0; timeout=0; busy=0; synchronizer flops=0; all counters=0.
REQ-026 Reset asserted mid-measurement SHALL abort it with no valid strobe after release.
REQ-027 After release the block SHALL wait for start.

Configuration
REQ-028 Macro ECHO_GLITCH_FILTER_EN defined: the synchronized echo SHALL be accepted only after 4 consecutive equal samples, adding 4 cycles of latency to both edges; shorter pulses are ignored.
REQ-029 Macro ECHO_GLITCH_FILTER_EN undefined: the filter SHALL be absent, and REQ-012 timing SHALL apply unchanged.

Structure
REQ-030 Shared package ultrasonic_pkg SHALL hold: the FSM state typedef, constants for the default TICKS_PER_CM, WAIT_LIMIT and MAX_CM, and the 9-bit distance typedef shared with display logic.
REQ-031 Sub-module echo_sync SHALL contain the synchronizer, the optional glitch filter and the rise/fall detector.

Verification
REQ-032 Bench: start, echo high 100 cycles later for 14500 cycles -> valid once, distance_cm=10, timeout=0.
REQ-033 Bench: echo high for 14499 cycles -> distance_cm=9.
REQ-034 Bench: start, no echo -> after 500000 cycles timeout=1, busy=0, no valid.
REQ-035 Bench: echo held high 600000 cycles -> timeout=1 at the cm count of 400, distance_cm keeps its prior value.
REQ-036 Bench: rst_n low mid-MEASURE -> all outputs 0 immediately; no valid after release.
REQ-037 Bench: with ECHO_GLITCH_FILTER_EN, a 2-cycle echo spike in WAIT_RISE -> ignored, state stays WAIT_RISE.
